// File: rtl/shift_reg_ctrl_if.sv
// Command and data bundle for the universal shift register sequencer.
// The master side issues commands and serial bits; the slave side is the
// sequencer, which returns the register contents, cell select code and status.
interface shift_reg_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] load_data;
    logic             ser_in_lsb;
    logic             ser_in_msb;
    logic [WIDTH-1:0] q;
    logic [1:0]       select;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_count,
        output load_data,
        output ser_in_lsb,
        output ser_in_msb,
        input  cmd_ready,
        input  q,
        input  select,
        input  ser_out,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_count,
        input  load_data,
        input  ser_in_lsb,
        input  ser_in_msb,
        output cmd_ready,
        output q,
        output select,
        output ser_out,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Sequencing stage for the universal shift register.
// Owns the WIDTH-bit register bank, drives the shared 2-bit select code to the
// per-bit D_i mux cells, and runs one LOAD/SHIFT/NOP command at a time to
// completion, pulsing done at the end. Every bit of the bank is rewritten on
// every edge from the D_i selection, so "hold" is simply select code 00.
module shift_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_reg_ctrl_if.slave bus
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    // Select codes understood by the D_i cells.
    localparam logic [1:0] SEL_HOLD       = 2'b00;
    localparam logic [1:0] SEL_LOAD       = 2'b01;
    localparam logic [1:0] SEL_FROM_LOWER = 2'b10;
    localparam logic [1:0] SEL_FROM_UPPER = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_lat;
    logic [WIDTH-1:0] data_lat;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [1:0]       sel;
    logic             ser_out_c;
    logic             accept;

    // A command is taken only while idle; anything presented while busy is ignored.
    assign accept = (state == IDLE) && bus.cmd_valid;

    // State register; reset returns to IDLE immediately, even mid-command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: NOP and zero-length shifts go straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_NOP:  state_nxt = DONE;
                        OP_LOAD: state_nxt = LOAD;
                        default: state_nxt = (bus.cmd_count == CNT_ZERO) ? DONE : SHIFT;
                    endcase
                end
            end
            LOAD:  state_nxt = DONE;
            // The edge that consumes the last remaining shift also leaves SHIFT.
            SHIFT: state_nxt = (remaining <= CNT_ONE) ? DONE : SHIFT;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture op and parallel word at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_lat   <= OP_NOP;
            data_lat <= '0;
        end else if (accept) begin
            op_lat   <= bus.cmd_op;
            data_lat <= bus.load_data;
        end
    end

    // Remaining shift count: loaded at acceptance, counts down once per shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (accept) begin
            remaining <= bus.cmd_op[1] ? bus.cmd_count : CNT_ZERO;
        end else if (state == SHIFT) begin
            remaining <= remaining - CNT_ONE;
        end
    end

    // Select code to the cells: load for the single LOAD cycle, shift direction in SHIFT.
    always_comb begin
        sel = SEL_HOLD;
        case (state)
            LOAD:    sel = SEL_LOAD;
            SHIFT:   sel = (op_lat == OP_SHL) ? SEL_FROM_LOWER : SEL_FROM_UPPER;
            default: sel = SEL_HOLD;
        endcase
    end

    // D_i mux for the whole bank; serial inputs fill the vacated end bit.
    always_comb begin
        q_nxt = q_r;
        case (sel)
            SEL_HOLD:       q_nxt = q_r;
            SEL_LOAD:       q_nxt = data_lat;
            SEL_FROM_LOWER: q_nxt = {q_r[WIDTH-2:0], bus.ser_in_lsb};
            SEL_FROM_UPPER: q_nxt = {bus.ser_in_msb, q_r[WIDTH-1:1]};
            default:        q_nxt = q_r;
        endcase
    end

    // Register bank, rewritten from the D_i selection on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else begin
            q_r <= q_nxt;
        end
    end

    // Serial output is the bit about to fall off the end during a shift cycle.
    always_comb begin
        ser_out_c = 1'b0;
        if (state == SHIFT) begin
            ser_out_c = (op_lat == OP_SHL) ? q_r[WIDTH-1] : q_r[0];
        end
    end

    assign bus.q         = q_r;
    assign bus.select    = sel;
    assign bus.ser_out   = ser_out_c;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: a table of commands with hand-computed final
// register values, hand-written busy/reset/back-to-back sequences, and a
// randomized run checked cycle by cycle against an arithmetic register model.
module tb_shift_reg_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int MODV  = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shift_reg_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]       op;
        int               count;
        logic [WIDTH-1:0] data;
        bit               lsb;
        bit               msb;
        logic [WIDTH-1:0] exp_q;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_q   = 0;   // model register value as an integer

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one shift edge to the model: multiply/divide by two, feed the serial bit.
    task automatic model_shift(input logic [1:0] op, input bit lsb, input bit msb);
        if (op == 2'b10) m_q = (m_q * 2 + int'(lsb)) % MODV;
        else             m_q = m_q / 2 + int'(msb) * (MODV / 2);
    endtask

    // Issue one command from IDLE and check every cycle until IDLE returns.
    task automatic run_cmd(input logic [1:0] op, input int count, input logic [WIDTH-1:0] data,
                           input bit lsb, input bit msb, input bit rnd);
        int         nb;
        logic [1:0] sel_exp;
        int         so_exp;
        bit         l_now, m_now;
        check("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_count  = count[CNT_W-1:0];
        bus.load_data  = data;
        bus.ser_in_lsb = lsb;
        bus.ser_in_msb = msb;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_count = CNT_W'($urandom);
        bus.load_data = WIDTH'($urandom);
        bus.cmd_op    = 2'($urandom);
        nb      = (op == 2'b01) ? 1 : ((op[1] && count > 0) ? count : 0);
        sel_exp = (op == 2'b01) ? 2'b01 : op;
        for (int k = 0; k < nb; k++) begin
            check("busy_high", bus.busy, 1);
            check("ready_low", bus.cmd_ready, 0);
            check("done_low_busy", bus.done, 0);
            check("select_busy", bus.select, sel_exp);
            check("q_step", bus.q, m_q);
            so_exp = (op == 2'b10) ? (m_q / (MODV / 2)) : ((op == 2'b11) ? (m_q % 2) : 0);
            check("ser_out_step", bus.ser_out, so_exp);
            if (rnd && op[1]) begin
                bus.ser_in_lsb = 1'($urandom);
                bus.ser_in_msb = 1'($urandom);
            end
            l_now = bus.ser_in_lsb;
            m_now = bus.ser_in_msb;
            tick();
            if (op == 2'b01) m_q = int'(data);
            else             model_shift(op, l_now, m_now);
        end
        check("done_pulse", bus.done, 1);
        check("select_done", bus.select, 0);
        check("ser_out_done", bus.ser_out, 0);
        check("q_done", bus.q, m_q);
        tick();
        check("done_cleared", bus.done, 0);
        check("ready_after", bus.cmd_ready, 1);
        check("select_idle", bus.select, 0);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_count  = '0;
        bus.load_data  = '0;
        bus.ser_in_lsb = 1'b0;
        bus.ser_in_msb = 1'b0;

        // Command table, starting from the reset value 0000.
        vecs[0] = '{2'b01, 0, 4'b1011, 1'b0, 1'b0, 4'b1011};
        vecs[1] = '{2'b10, 2, 4'b0000, 1'b1, 1'b0, 4'b1111};
        vecs[2] = '{2'b11, 3, 4'b1010, 1'b0, 1'b0, 4'b0001};
        vecs[3] = '{2'b10, 0, 4'b1111, 1'b1, 1'b1, 4'b0001};
        vecs[4] = '{2'b00, 5, 4'b1110, 1'b1, 1'b1, 4'b0001};
        vecs[5] = '{2'b10, 5, 4'b1111, 1'b0, 1'b1, 4'b0000};
        vecs[6] = '{2'b01, 7, 4'b0110, 1'b1, 1'b1, 4'b0110};
        vecs[7] = '{2'b11, 1, 4'b0000, 1'b0, 1'b1, 4'b1011};
        vecs[8] = '{2'b11, 6, 4'b0000, 1'b1, 1'b1, 4'b1111};

        repeat (2) @(posedge clk);
        #1;
        check("rst_q", bus.q, 0);
        check("rst_select", bus.select, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        m_q = 0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].count, vecs[i].data, vecs[i].lsb, vecs[i].msb, 1'b0);
            check($sformatf("table_q[%0d]", i), bus.q, vecs[i].exp_q);
        end

        // Long shift with a LOAD held on the bus, then reset during shift cycle 3.
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'b10;
        bus.cmd_count  = 3'd7;
        bus.ser_in_lsb = 1'b1;
        tick();
        bus.cmd_op    = 2'b01;
        bus.load_data = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            check("held_load_ready_low", bus.cmd_ready, 0);
            check("held_load_select", bus.select, 2'b10);
            check("held_load_q", bus.q, m_q);
            tick();
            model_shift(2'b10, 1'b1, 1'b0);
        end
        check("shift3_q", bus.q, m_q);
        check("shift3_select", bus.select, 2'b10);
        rst_n = 1'b0;
        #1;
        check("midrst_q", bus.q, 0);
        check("midrst_select", bus.select, 0);
        check("midrst_ready", bus.cmd_ready, 1);
        check("midrst_done", bus.done, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ser_out", bus.ser_out, 0);
        m_q = 0;
        tick();
        check("inrst_q", bus.q, 0);
        check("inrst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        check("postrst_accept_select", bus.select, 2'b01);
        check("postrst_accept_busy", bus.busy, 1);
        bus.cmd_valid = 1'b0;
        tick();
        check("postrst_load_q", bus.q, 4'b1001);
        check("postrst_load_done", bus.done, 1);
        tick();
        check("postrst_ready", bus.cmd_ready, 1);
        m_q = 9;

        // Held NOP: accepted again in the first IDLE cycle after done.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        tick();
        check("b2b_done1", bus.done, 1);
        check("b2b_ready1", bus.cmd_ready, 0);
        tick();
        check("b2b_idle_done", bus.done, 0);
        check("b2b_idle_ready", bus.cmd_ready, 1);
        tick();
        check("b2b_done2", bus.done, 1);
        check("b2b_q", bus.q, m_q);
        bus.cmd_valid = 1'b0;
        tick();
        check("b2b_final_ready", bus.cmd_ready, 1);

        // Randomized commands with serial inputs changing every shift cycle.
        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 7)), WIDTH'($urandom),
                    1'($urandom), 1'($urandom), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencing stage for the universal shift register.
- Holds the WIDTH-bit register bank that consumes the per-bit D_i mux outputs, and drives the shared 2-bit select code to those cells.
- Accepts load and shift commands over a valid/ready handshake and runs each to completion.
- Pulses done when a command finishes and provides a serial output.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CNT_W, 3, width of the shift-count field; counts 0..2^CNT_W-1 are legal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_op  input  2  00 NOP, 01 LOAD, 10 SHIFT_LEFT (toward MSB), 11 SHIFT_RIGHT.
- cmd_count  input  CNT_W  number of shift cycles; ignored for NOP/LOAD.
- load_data  input  WIDTH  parallel word for LOAD.
- ser_in_lsb  input  1  bit entering q[0] on SHIFT_LEFT.
- ser_in_msb  input  1  bit entering q[WIDTH-1] on SHIFT_RIGHT.
- q  output  WIDTH  register contents.
- select  output  2  code driven to the D_i cells: 00 hold, 01 load, 10 take Q(i-1), 11 take Q(i+1).
- ser_out  output  1  bit leaving the register in the current shift cycle.
- busy  output  1  high in LOAD/SHIFT/DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0) is immediate, including mid-command:
  - q=0, state=IDLE, select=00, done=0, busy=0, ser_out=0, cmd_ready=1 while rst_n is low, internal count=0.
  - Latched op and data are discarded.
- Register update rule, applied every edge: bit i takes the D_i selection.
  - 00 → q[i]; 01 → data[i]; 10 → q[i-1]; 11 → q[i+1].
  - Boundary bits: q[-1] = ser_in_lsb, q[WIDTH] = ser_in_msb.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, select=00.
  - On cmd_valid & cmd_ready at an edge: latch cmd_op, load_data, cmd_count.
  - Next state:
    - NOP → DONE.
    - LOAD → LOAD.
    - SHIFT op with count 0 → DONE.
    - SHIFT op with count>0 → SHIFT, with remaining = count.
- LOAD:
  - select=01 for exactly one cycle; q takes the latched data at the edge ending LOAD.
  - Next state → DONE.
- SHIFT:
  - select=10 or 11 per the latched op; one bit shifts per cycle.
  - remaining decrements each cycle; when remaining==1, next state → DONE.
  - Exactly count shifts occur. Counts > WIDTH are legal and keep shifting in serial input.
- DONE: done=1, select=00, next state → IDLE.
- cmd_ready is low from the cycle after acceptance until IDLE is re-entered.
  - cmd_valid is ignored while busy; no queuing.
  - A held cmd_valid is accepted in the first IDLE cycle, the cycle after done.
- Latency, with acceptance at edge E0:
  - LOAD: q updated at E1, done high in the cycle after E1.
  - SHIFT n: q final after E_n, done high in the cycle after E_n.
  - NOP or count 0: done high in the cycle after E0.
- ser_out (combinational):
  - SHIFT_LEFT in SHIFT: q[WIDTH-1].
  - SHIFT_RIGHT in SHIFT: q[0].
  - Otherwise: 0.
- Serial inputs are sampled at each SHIFT edge, so they may change every cycle.
- cmd_count and load_data are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset: assert rst_n=0 mid-simulation → q=0000, select=00, cmd_ready=1, done=0, without waiting for a clock edge.
- LOAD 4'b1011 → select=01 for one cycle, q=1011 after E1, done pulses for one cycle, cmd_ready back to 1 the next cycle.
- From q=1011, SHIFT_LEFT count=2 with ser_in_lsb=1 → q 0111 then 1111; ser_out 1 then 0; select=10 for exactly 2 cycles; then done.
- From q=1111, SHIFT_RIGHT count=3 with ser_in_msb=0 → q 0111, 0011, 0001; ser_out 1,1,1; then done.
- SHIFT count=0, and NOP → q unchanged, done one cycle after acceptance, select stays 00.
- Busy / back-to-back / reset mid-shift:
  - SHIFT count=7 with cmd_valid held and a new LOAD presented → the LOAD is not accepted until IDLE.
  - Deassert rst_n during cycle 3 of the shift → q=0, state IDLE immediately.
  - After reset release, the LOAD is accepted on the first edge.
